// File: rtl/cpu_mem_arbiter_pkg.sv
// ============================================================================
// Module   : cpu_mem_arbiter_pkg
// Brief    : Shared requester IDs, size encodings and like-SRAM bus widths.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_mem_arbiter_pkg;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_SW = 4;

endpackage

`default_nettype wire

// File: rtl/cpu_mem_arbiter_id_fifo.sv
// ============================================================================
// Module   : arb_id_fifo
// Brief    : 1-bit wide circular FIFO holding the owner of each outstanding
//            memory transaction; push and pop may happen in the same cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_push,
    input  logic i_pop,
    input  logic i_din,
    output logic o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;

    logic w_push;
    logic w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rptr];

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
// ============================================================================
// Module   : cpu_mem_arbiter
// Brief    : Shares one like-SRAM port between instruction fetch and data
//            access; routes in-order responses back via an owner-ID FIFO.
//            Define ARB_RR_EN for round-robin, else fixed data priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic [BUS_AW-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [BUS_DW-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [BUS_SW-1:0] data_wstrb,
    input  logic [BUS_AW-1:0] data_addr,
    input  logic [BUS_DW-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [BUS_DW-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [BUS_SW-1:0] mem_wstrb,
    output logic [BUS_AW-1:0] mem_addr,
    output logic [BUS_DW-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [BUS_DW-1:0] mem_rdata
);

    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_sel_data;
    logic w_grant_ok;
    logic w_accept;
    logic w_pop;

`ifdef ARB_RR_EN
    logic r_last_grant;

    // Reset to "instruction last" so data wins the first contended cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= ID_INST;
        end else if (w_accept) begin
            r_last_grant <= w_sel_data;
        end
    end

    assign w_sel_data = data_req && (!inst_req || (r_last_grant == ID_INST));
`else
    assign w_sel_data = data_req;
`endif

    // Full is registered state, so a pop this cycle re-opens the port next cycle.
    assign w_grant_ok = !reset && !w_full && (inst_req || data_req);

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_grant_ok) begin
            mem_req = 1'b1;
            if (w_sel_data) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_size  = SIZE_W;
                mem_addr  = inst_addr;
            end
        end
    end

    assign w_accept     = mem_req && mem_addr_ok;
    assign inst_addr_ok = w_accept && !w_sel_data;
    assign data_addr_ok = w_accept && w_sel_data;

    // Responses with nothing outstanding are dropped rather than routed.
    assign w_pop        = mem_data_ok && !w_empty && !reset;
    assign inst_data_ok = w_pop && (w_head == ID_INST);
    assign data_data_ok = w_pop && (w_head == ID_DATA);
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;

    arb_id_fifo #(
        .DEPTH   (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_din   (w_sel_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
// ============================================================================
// Module   : tb_cpu_mem_arbiter
// Brief    : Scoreboard bench for cpu_mem_arbiter (fixed or ARB_RR_EN build).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    cpu_mem_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        id;
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } gexp_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    logic  own[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_data_ok = 1'b0;
    endtask

    task automatic req_i(input logic [31:0] a);
        gexp_t g;
        inst_req  = 1'b1;
        data_req  = 1'b0;
        inst_addr = a;
        g = '{id: 1'b0, addr: a, wr: 1'b0, size: 2'd2, wstrb: 4'h0, wdata: 32'h0};
        gq.push_back(g);
    endtask

    task automatic exp_d();
        gexp_t g;
        g = '{id: 1'b1, addr: data_addr, wr: data_wr, size: data_size,
              wstrb: data_wstrb, wdata: data_wdata};
        gq.push_back(g);
    endtask

    task automatic req_d(input logic wr, input logic [1:0] sz, input logic [3:0] st,
                         input logic [31:0] a, input logic [31:0] wd);
        inst_req   = 1'b0;
        data_req   = 1'b1;
        data_wr    = wr;
        data_size  = sz;
        data_wstrb = st;
        data_addr  = a;
        data_wdata = wd;
        exp_d();
    endtask

    task automatic rsp(input logic id, input logic [31:0] v);
        rexp_t r;
        mem_data_ok = 1'b1;
        mem_rdata   = v;
        r = '{id: id, data: v};
        rq.push_back(r);
    endtask

    // Monitor: every grant and every response the DUT presents is popped and compared.
    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        if (inst_addr_ok || data_addr_ok) begin
            if (gq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_grant: got i=%b d=%b expected none", inst_addr_ok, data_addr_ok);
            end else begin
                g = gq.pop_front();
                chk("grant_owner", {30'b0, data_addr_ok, inst_addr_ok}, g.id ? 32'd2 : 32'd1);
                chk("grant_addr",  mem_addr,  g.addr);
                chk("grant_wr",    {31'b0, mem_wr}, {31'b0, g.wr});
                chk("grant_size",  {30'b0, mem_size}, {30'b0, g.size});
                chk("grant_wstrb", {28'b0, mem_wstrb}, {28'b0, g.wstrb});
                chk("grant_wdata", mem_wdata, g.wdata);
            end
        end
        if (inst_data_ok || data_data_ok) begin
            if (rq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_resp: got i=%b d=%b expected none", inst_data_ok, data_data_ok);
            end else begin
                r = rq.pop_front();
                chk("resp_owner", {30'b0, data_data_ok, inst_data_ok}, r.id ? 32'd2 : 32'd1);
                chk("resp_rdata", r.id ? data_rdata : inst_rdata, r.data);
                chk("resp_other_rdata", r.id ? inst_rdata : data_rdata, 32'h0);
            end
        end
    end

    initial begin
        reset = 1'b1; inst_req = 1'b1; data_req = 1'b1;
        inst_addr = 32'h1c00_0000; data_addr = 32'h2000; data_wr = 1'b1;
        data_size = 2'd2; data_wstrb = 4'hf; data_wdata = 32'h1234_5678;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h5a5a_5a5a;

        // Reset held with requests active: everything quiet.
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_mem_req",  {31'b0, mem_req}, 32'h0);
            chk("reset_addr_ok",  {30'b0, inst_addr_ok, data_addr_ok}, 32'h0);
            chk("reset_data_ok",  {30'b0, inst_data_ok, data_data_ok}, 32'h0);
            chk("reset_data_out", mem_addr | mem_wdata | inst_rdata | data_rdata, 32'h0);
            tick();
        end
        reset = 1'b0; idle();
        req_i(32'h1c00_0000);
        @(negedge clk);
        chk("post_reset_mem_addr", mem_addr, 32'h1c00_0000);
        chk("post_reset_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h1);
        tick(); idle();
        rsp(1'b0, 32'h1111_1111); tick(); idle();

        // Request withdrawn before acceptance leaves nothing outstanding.
        mem_addr_ok = 1'b0; data_req = 1'b1;
        @(negedge clk);
        chk("drop_mem_req", {31'b0, mem_req}, 32'h1);
        tick(); idle(); mem_addr_ok = 1'b1;

        // Contention for 4 cycles, then full with a response in the 5th cycle.
        inst_addr = 32'h1000; data_wr = 1'b1; data_size = 2'd1;
        data_wstrb = 4'hc; data_addr = 32'h2000; data_wdata = 32'hdead_beef;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            own[i] = (i % 2 == 0) ? 1'b1 : 1'b0;
`else
            own[i] = 1'b1;
`endif
            inst_req = 1'b1; data_req = 1'b1;
            if (own[i]) exp_d(); else req_i(32'h1000);
            data_req = 1'b1;
            tick();
        end
        rsp(own[0], 32'ha000_0000);
        @(negedge clk);
        chk("full_mem_req", {31'b0, mem_req}, 32'h0);
        tick();
        mem_data_ok = 1'b0;
        exp_d();
        @(negedge clk);
        chk("after_full_mem_req", {31'b0, mem_req}, 32'h1);
        tick(); idle();
        for (int i = 1; i < 4; i++) begin
            rsp(own[i], 32'ha000_0000 | i); tick(); idle();
        end
        rsp(1'b1, 32'ha000_0004); tick(); idle();

        // In-order routing across owners.
        req_i(32'h100); tick(); idle();
        req_d(1'b0, 2'd2, 4'h0, 32'h200, 32'h0); tick(); idle();
        req_i(32'h104); tick(); idle();
        rsp(1'b0, 32'h0000_aaaa); tick(); idle();
        rsp(1'b1, 32'h0000_bbbb); tick(); idle();
        rsp(1'b0, 32'h0000_cccc); tick(); idle();

        // Steady occupancy of 2 with push+pop every cycle, crossing the wrap.
        req_i(32'h300); tick(); idle();
        req_d(1'b0, 2'd0, 4'h0, 32'h401, 32'h0); tick(); idle();
        req_d(1'b1, 2'd0, 4'h1, 32'h402, 32'h55); rsp(1'b0, 32'hb000_0001); tick(); idle();
        req_i(32'h304);                          rsp(1'b1, 32'hb000_0002); tick(); idle();
        req_d(1'b1, 2'd1, 4'h3, 32'h404, 32'h66); rsp(1'b1, 32'hb000_0003); tick(); idle();
        req_i(32'h308);                          rsp(1'b0, 32'hb000_0004); tick(); idle();
        req_i(32'h30c); tick(); idle();
        req_d(1'b0, 2'd2, 4'h0, 32'h408, 32'h0); tick(); idle();
        inst_req = 1'b1;
        @(negedge clk);
        chk("simul_full_mem_req", {31'b0, mem_req}, 32'h0);
        tick(); idle();
        rsp(1'b1, 32'hc000_0001); tick(); idle();
        rsp(1'b0, 32'hc000_0002); tick(); idle();
        rsp(1'b0, 32'hc000_0003); tick(); idle();
        rsp(1'b1, 32'hc000_0004); tick(); idle();

        // Mid-operation reset discards outstanding transactions.
        req_i(32'h500); tick(); idle();
        req_d(1'b0, 2'd2, 4'h0, 32'h600, 32'h0); tick(); idle();
        reset = 1'b1; rq.delete(); tick(); reset = 1'b0;

        // Spurious responses on an empty FIFO.
        for (int i = 0; i < 2; i++) begin
            mem_data_ok = 1'b1; mem_rdata = 32'heeee_eeee;
            @(negedge clk);
            chk("spurious_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'h0);
            chk("spurious_rdata", inst_rdata | data_rdata, 32'h0);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            req_i(32'h700 + 32'(i * 4));
            @(negedge clk);
            chk("refill_mem_req", {31'b0, mem_req}, 32'h1);
            tick(); idle();
        end
        inst_req = 1'b1;
        @(negedge clk);
        chk("refill_full_mem_req", {31'b0, mem_req}, 32'h0);
        tick(); idle();
        for (int i = 0; i < 4; i++) begin
            rsp(1'b0, 32'hd000_0000 | i); tick(); idle();
        end

        tick();
        chk("grant_queue_drained", gq.size(), 32'h0);
        chk("resp_queue_drained",  rq.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Shares the single like-SRAM memory port between the fetch stage's instruction requester and the memory stage's data requester. It sits between the CPU pipeline and the external memory/bridge. It arbitrates address-phase requests and records the owner of every accepted transaction in an in-order ID FIFO. Each returning `data_ok`/`rdata` is routed back to the requester that owns it.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 4: maximum accepted-but-unanswered transactions; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `inst_req`  in  1  instruction read request
- `inst_addr`  in  32  fetch address
- `inst_addr_ok`  out  1  instruction request accepted this cycle
- `inst_data_ok`  out  1  instruction data returned this cycle
- `inst_rdata`  out  32  instruction word
- `data_req`  in  1  data request
- `data_wr`  in  1  1 = write
- `data_size`  in  2  0 = byte, 1 = half, 2 = word
- `data_wstrb`  in  4  byte enables
- `data_addr`  in  32  data address
- `data_wdata`  in  32  store data
- `data_addr_ok`  out  1  data request accepted
- `data_data_ok`  out  1  data response (reads and writes)
- `data_rdata`  out  32  load data
- `mem_req`, `mem_wr`, `mem_size[1:0]`, `mem_wstrb[3:0]`, `mem_addr[31:0]`, `mem_wdata[31:0]`  out  request to memory
- `mem_addr_ok`  in  1  memory accepted request
- `mem_data_ok`  in  1  memory response (in order)
- `mem_rdata`  in  32  response data

## Operation
- Grant is combinational each cycle from `inst_req`, `data_req`, the arbitration policy and the `full` flag. A request is offered to memory only if the FIFO is not full.
- Instruction requests drive `mem_wr=0`, `mem_size=2`, `mem_wstrb=0`, `mem_wdata=0`.
- Data requests pass all data fields through unchanged.
- Acceptance is `mem_req && mem_addr_ok`. On acceptance the arbiter pushes the owner ID (0 = inst, 1 = data) into the ID FIFO and asserts the owner's `*_addr_ok` in the same cycle. The other requester's `addr_ok` stays 0.
- On `mem_data_ok` the arbiter pops the FIFO head and asserts `<owner>_data_ok` with `<owner>_rdata = mem_rdata`. The non-owner's `rdata` is 0.
- Occupancy counter `cnt` is `$clog2(MAX_OUTSTANDING)+1` bits wide:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged, and both take effect.
- `full = (cnt == MAX_OUTSTANDING)`. While full, `mem_req=0` and both `addr_ok=0`. A pop in that cycle does not re-enable granting until the next cycle.
- `mem_data_ok` while the FIFO is empty is a protocol violation: it is ignored, no `*_data_ok` is asserted, and `cnt` stays 0.
- A requester may drop `req` before `addr_ok`. The grant is recomputed each cycle, and no grant is held.
- Reset mid-operation clears the FIFO, `cnt` and the arbitration state. Responses still in flight in memory are the system's responsibility, because memory is reset together with the arbiter.

## Timing
- Address phase: zero-cycle combinational pass-through from `*_req` to `mem_req` and from `mem_addr_ok` to `*_addr_ok`.
- Response phase: zero-cycle routing from `mem_data_ok` to `*_data_ok`. No registers sit on the data path.
- The minimum request-to-response latency is the memory's own latency. The arbiter adds none.
- Throughput: one acceptance and one response per cycle.
- Reset values (during and immediately after reset, with idle inputs): all `*_addr_ok`, `*_data_ok` and `mem_req` are 0, all data outputs are 0, `cnt=0`, and the round-robin pointer favours data.

## Configuration
- `ARB_RR_EN` defined:
  - Round-robin arbitration. A 1-bit pointer `last_grant` updates on every acceptance.
  - When both requesters want the port, the one not last granted wins.
- `ARB_RR_EN` undefined:
  - Fixed priority, data over instruction. No pointer register exists.
  - Instruction is granted only in cycles where `data_req=0`.

## Structure
- Shared package: requester ID constants (`ID_INST=0`, `ID_DATA=1`), size encodings (`SIZE_B/H/W`), and the like-SRAM bus width constants.
- One sub-module, `arb_id_fifo`: a 1-bit wide, `MAX_OUTSTANDING`-deep circular FIFO.
  - Read/write pointers wrap modulo depth.
  - It exposes `push`, `pop`, `head`, `full` and `empty`.
  - It supports push and pop in the same cycle.

## Test plan
- Reset: hold `reset` 3 cycles with both requests high. All outputs stay 0. After release, `inst_req=1` with `mem_addr_ok=1` gives `inst_addr_ok=1` and `mem_addr=inst_addr=0x1c000000`.
- Contention: `inst_req=data_req=1` every cycle with `mem_addr_ok=1` for 4 cycles.
  - Fixed priority: 4 data grants.
  - `ARB_RR_EN`: grants alternate D, I, D, I.
- Ordering: accept I@0x100, D-read@0x200, I@0x104. Return responses 0xAAAA, 0xBBBB, 0xCCCC. The bench must see `inst_data_ok`/0xAAAA, then `data_data_ok`/0xBBBB, then `inst_data_ok`/0xCCCC.
- Full: accept 4 requests with no response. On the 5th cycle `mem_req=0`. One response arrives that cycle, and the next cycle a grant is issued again.
- Simultaneous: with `cnt=2`, acceptance and `mem_data_ok` in the same cycle leave `cnt=2`. The head is routed correctly and the new ID is enqueued at the tail, including across the pointer wrap.
- Spurious: `mem_data_ok=1` with the FIFO empty produces no `*_data_ok`, and `cnt` remains 0.
